// File: rtl/rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_fifo
// Brief    : Store-and-forward receive FIFO for the MAC RX AXI-Stream path.
//            Frames are released only once their last beat arrives with good
//            status; bad-status and overflowing frames are rolled back.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  mac_clk,
   input  logic                  mac_rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [31:0]           stat_good_frames,
   output logic [31:0]           stat_bad_drops,
   output logic [31:0]           stat_ovf_drops,
   output logic [ADDR_WIDTH:0]   fifo_level
);

   localparam int                DEPTH      = 2 ** ADDR_WIDTH;
   localparam int                ENTRY_W    = 1 + KEEP_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [0:0] {
      ACCEPT = 1'b0,
      DROP   = 1'b1
   } wr_state_t;

   logic [ENTRY_W-1:0] mem [DEPTH];

   wr_state_t           state, state_next;
   logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_next;
   logic [ADDR_WIDTH:0] commit_ptr, commit_next;
   logic [ADDR_WIDTH:0] rd_ptr, rd_ptr_next;
   logic                mem_we;
   logic                inc_good, inc_bad, inc_ovf;
   logic                beat;
   logic                full;
   logic                load;

   // The MAC cannot be stalled, so ready simply follows reset release.
   assign s_axis_tready = mac_rst;
   assign beat          = s_axis_tvalid & mac_rst;
   assign full          = (wr_ptr - rd_ptr) == FULL_LEVEL;
   // Only committed entries are visible to the read side.
   assign load          = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);
   assign rd_ptr_next   = load ? rd_ptr + PTR_ONE : rd_ptr;

   // Write FSM: next state, pointer updates and statistics strobes.
   always_comb begin
      state_next  = state;
      wr_ptr_next = wr_ptr;
      commit_next = commit_ptr;
      mem_we      = 1'b0;
      inc_good    = 1'b0;
      inc_bad     = 1'b0;
      inc_ovf     = 1'b0;
      if (beat) begin
         case (state)
            ACCEPT: begin
               if (full) begin
                  // Out of room: roll back the partial frame.
                  wr_ptr_next = commit_ptr;
                  if (s_axis_tlast) inc_ovf = 1'b1;
                  else              state_next = DROP;
               end else begin
                  mem_we      = 1'b1;
                  wr_ptr_next = wr_ptr + PTR_ONE;
                  if (s_axis_tlast) begin
                     if (s_axis_tuser) begin
                        wr_ptr_next = commit_ptr;
                        inc_bad     = 1'b1;
                     end else begin
                        commit_next = wr_ptr + PTR_ONE;
                        inc_good    = 1'b1;
                     end
                  end
               end
            end
            DROP: begin
               if (s_axis_tlast) begin
                  inc_ovf    = 1'b1;
                  state_next = ACCEPT;
               end
            end
            default: state_next = ACCEPT;
         endcase
      end
   end

   // Write FSM state, pointers, counters and the registered level.
   always_ff @(posedge mac_clk) begin
      if (!mac_rst) begin
         state            <= ACCEPT;
         wr_ptr           <= '0;
         commit_ptr       <= '0;
         rd_ptr           <= '0;
         stat_good_frames <= '0;
         stat_bad_drops   <= '0;
         stat_ovf_drops   <= '0;
         fifo_level       <= '0;
      end else begin
         state      <= state_next;
         wr_ptr     <= wr_ptr_next;
         commit_ptr <= commit_next;
         rd_ptr     <= rd_ptr_next;
         fifo_level <= wr_ptr_next - rd_ptr_next;
         if (inc_good) stat_good_frames <= stat_good_frames + 32'd1;
         if (inc_bad)  stat_bad_drops   <= stat_bad_drops + 32'd1;
         if (inc_ovf)  stat_ovf_drops   <= stat_ovf_drops + 32'd1;
      end
   end

   // Frame buffer write port; contents need no reset since pointers gate reads.
   always_ff @(posedge mac_clk) begin
      if (mem_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   end

   // Output register: refill when empty or when the current beat is taken.
   always_ff @(posedge mac_clk) begin
      if (!mac_rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (load) begin
         {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
         m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: doc/rx_frame_fifo.md
# rx_frame_fifo

Store-and-forward receive FIFO sitting directly downstream of the `mac` RX AXI-Stream port (`rx_axis_*`) in the `mac_clk` domain. It buffers each received frame and releases it to the user side only after its last beat arrives with a good status, discarding CRC/framing-error frames and frames that overflow the buffer. The MAC RX path cannot be back-pressured, so the block never deasserts ready outside reset.

## Interface
- `DATA_WIDTH`, 32: AXIS data width (matches `AXIS_DATA_WIDTH`).
- `KEEP_WIDTH`, `DATA_WIDTH/8`: byte-enable width.
- `ADDR_WIDTH`, 6: log2 of buffer depth; depth = `2**ADDR_WIDTH` beats.

Ports:
- `mac_clk` in 1: single clock; all logic on rising edge.
- `mac_rst` in 1: reset, synchronous, active-low.
- `s_axis_tdata` in `DATA_WIDTH`: beat data from MAC `rx_axis_tdata`.
- `s_axis_tkeep` in `KEEP_WIDTH`: byte enables.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tlast` in 1: last beat of frame.
- `s_axis_tuser` in 1: bad-frame flag, sampled only on the tlast beat; top level drives `rx_crc_error | rx_frame_error`.
- `s_axis_tready` out 1: 1 whenever `mac_rst`=1, 0 while in reset.
- `m_axis_tdata` out `DATA_WIDTH`: released frame data.
- `m_axis_tkeep` out `KEEP_WIDTH`: released byte enables.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tlast` out 1: last beat of released frame.
- `m_axis_tready` in 1: user-side ready.
- `stat_good_frames` out 32: frames committed.
- `stat_bad_drops` out 32: frames dropped on `s_axis_tuser`=1.
- `stat_ovf_drops` out 32: frames dropped on overflow.
- `fifo_level` out `ADDR_WIDTH+1`: `wr_ptr - rd_ptr`.

## Operation
- Storage: `2**ADDR_WIDTH` entries of `{tlast, tkeep, tdata}`. Pointers `wr_ptr`, `commit_ptr`, and `rd_ptr` are `ADDR_WIDTH+1` bits and wrap modulo `2**(ADDR_WIDTH+1)`. Memory is indexed by the low `ADDR_WIDTH` bits.
- Full: `wr_ptr - rd_ptr == 2**ADDR_WIDTH`, evaluated on pre-edge register values. A slot freed by a read in the same cycle is not usable until the next cycle.
- Write FSM has two states:
  - ACCEPT (reset state). On each accepted beat:
    - If full: enter DROP, set `wr_ptr <= commit_ptr`. If this beat also has tlast, do not enter DROP; instead count `stat_ovf_drops` and stay in ACCEPT.
    - Else: write the entry and increment `wr_ptr`.
    - On a tlast beat that is written: if `s_axis_tuser`=0, set `commit_ptr <= wr_ptr+1` and increment `stat_good_frames`. If `s_axis_tuser`=1, set `wr_ptr <= commit_ptr` and increment `stat_bad_drops`.
  - DROP: discard all beats. On a tlast beat, increment `stat_ovf_drops` and return to ACCEPT. In DROP, `s_axis_tuser` is ignored and `stat_bad_drops` is not incremented.
- A frame longer than depth is always dropped as overflow.
- Read side: a single output register.
  - It loads `mem[rd_ptr]` and increments `rd_ptr` when `rd_ptr != commit_ptr` and (`m_axis_tvalid`=0 or `m_axis_tready`=1).
  - Otherwise, a handshake clears `m_axis_tvalid`.
  - `m_axis_tdata`, `m_axis_tkeep`, and `m_axis_tlast` hold until the handshake completes.
- Only committed data is ever read, so a rollback never affects the read side.
- Statistics counters wrap at 2^32.
- `s_axis_tvalid`=0 cycles inside a frame are idle and do not change state.

## Timing
- Reset (`mac_rst`=0 at an edge) clears:
  - all pointers and FSM state to ACCEPT;
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`;
  - all `stat_*` counters and `fifo_level`.
- Reset mid-frame discards the partial frame and any uncommitted or unread data. The first beat accepted after release starts a new frame.
- Latency: tlast of a good frame is accepted at edge N, so `commit_ptr` updates at N. The first beat is loaded at N+1, giving `m_axis_tvalid`=1 during cycle N+1..N+2.
- Throughput: one beat per cycle with `m_axis_tready` held at 1.
- Back-to-back frames: a tlast beat followed by a first beat in the next cycle is legal.
- A commit and a read of a prior frame in the same cycle are both honoured.
- `fifo_level` is registered and reflects rollbacks the cycle after they occur.

## Test plan
- **Good frame.** `ADDR_WIDTH`=4, `m_axis_tready`=1. Send 12 beats, `tkeep`=4'hF, data 32'hA1B2C3D4 … 32'h3E5F7A9B, with tuser=0 on tlast.
  Expect: `m_axis_tvalid` rises 1 cycle after the tlast edge; the identical 12 beats come out with tlast on 32'h3E5F7A9B; `stat_good_frames`=1.
- **Bad frame.** Same frame with tuser=1 on tlast.
  Expect: `m_axis_tvalid` never asserts; `stat_bad_drops`=1; `fifo_level` returns to 0.
- **Overflow.** `ADDR_WIDTH`=4, `m_axis_tready`=0. Send a 20-beat frame.
  Expect: `stat_ovf_drops`=1 and `fifo_level`=0. A following 4-beat good frame is then delivered intact once `m_axis_tready`=1.
- **Back-pressure.** Two back-to-back 5-beat good frames; toggle `m_axis_tready` 1,0,1,0…
  Expect: all 10 beats in order, data stable while stalled, exactly 2 tlast beats, `stat_good_frames`=2.
- **Partial last beat.** Final beat with `tkeep`=4'b0011.
  Expect: output tlast beat carries `tkeep`=4'b0011 with unchanged data.
- **Reset mid-frame.** Assert `mac_rst`=0 for 1 cycle after beat 3 of a 12-beat frame, then send a fresh 4-beat good frame.
  Expect: only the 4-beat frame is output; counters show `stat_good_frames`=1 after the reset.
